dual_port_ram_be: RTL and testbench

Parametrised true dual-port RAM, successor of the 8-bit/1K dual-port data RAM in the LSU path. Adds configurable width/depth, per-byte write strobes, and an optional registered read with valid handshake. It also adds deterministic write-collision resolution and a post-reset zero-clear sweep so memory contents are defined before first use. Sits between the LSU (port A) and a debug/DMA or second-hart port (port B).

---
 rtl/dpram_pkg.sv | 19 +
 rtl/dpram_core.sv | 52 +++++
 rtl/dual_port_ram_be.sv | 144 ++++++++++++++
 tb/tb_dual_port_ram_be.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// Shared types, read-latency encodings and the byte-lane merge helper for dual_port_ram_be.
package dpram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dpram_state_e;

  localparam int unsigned RD_COMB = 0;
  localparam int unsigned RD_REG  = 1;

  // Select the new byte where its strobe is set, otherwise keep the old byte.
  function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       be);
    return be ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/dpram_core.sv
// Storage array with two byte-strobed write ports (port A wins shared lanes) and two
// asynchronous read ports.
module dpram_core
  import dpram_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  a_we,
  input  logic [DATA_W/8-1:0]   a_be,
  input  logic [ADDR_W-1:0]     a_addr,
  input  logic [DATA_W-1:0]     a_wdata,
  output logic [DATA_W-1:0]     a_rdata_c,
  input  logic                  b_we,
  input  logic [DATA_W/8-1:0]   b_be,
  input  logic [ADDR_W-1:0]     b_addr,
  input  logic [DATA_W-1:0]     b_wdata,
  output logic [DATA_W-1:0]     b_rdata_c
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned BE_W  = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] a_word_c;
  logic [DATA_W-1:0] b_word_c;
  logic              same_c;

  assign a_rdata_c = mem[a_addr];
  assign b_rdata_c = mem[b_addr];

  // On a same-address double write, A's word is built on top of B's merge so B-only lanes survive.
  always_comb begin
    a_word_c = '0;
    b_word_c = '0;
    same_c   = a_we & b_we & (a_addr == b_addr);
    for (int unsigned i = 0; i < BE_W; i++) begin
      b_word_c[8*i +: 8] = byte_merge(b_rdata_c[8*i +: 8], b_wdata[8*i +: 8], b_be[i]);
    end
    for (int unsigned i = 0; i < BE_W; i++) begin
      a_word_c[8*i +: 8] = byte_merge(same_c ? b_word_c[8*i +: 8] : a_rdata_c[8*i +: 8],
                                      a_wdata[8*i +: 8], a_be[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_word_c;
    if (b_we && !same_c) mem[b_addr] <= b_word_c;
  end

endmodule

// File: rtl/dual_port_ram_be.sv
// True dual-port byte-strobed RAM: init FSM, accept gating, read registers, collision flag.
// Define DPRAM_INIT_CLEAR_EN to zero-clear the whole array after every reset.
module dual_port_ram_be
  import dpram_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_req,
  input  logic                a_we,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_wdata,
  output logic [DATA_W-1:0]   a_rdata,
  output logic                a_rvalid,
  input  logic                b_req,
  input  logic                b_we,
  input  logic [DATA_W/8-1:0] b_be,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic [DATA_W-1:0]   b_rdata,
  output logic                b_rvalid,
  output logic                init_done,
  output logic                collision
);

  localparam int unsigned BE_W = DATA_W / 8;

  dpram_state_e      state_q, state_d;
  logic              a_acc_c, b_acc_c, a_rd_c, b_rd_c;
  logic              core_a_we_c;
  logic [BE_W-1:0]   core_a_be_c;
  logic [ADDR_W-1:0] core_a_addr_c;
  logic [DATA_W-1:0] core_a_wdata_c;
  logic [DATA_W-1:0] a_mem_c, b_mem_c;

`ifdef DPRAM_INIT_CLEAR_EN
  localparam int unsigned DEPTH = 1 << ADDR_W;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clr_addr_q <= '0;
    else        clr_addr_q <= clr_addr_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= CLEAR;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
`ifdef DPRAM_INIT_CLEAR_EN
    clr_addr_d = clr_addr_q;
`endif
    case (state_q)
      CLEAR: begin
`ifdef DPRAM_INIT_CLEAR_EN
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == ADDR_W'(DEPTH - 1)) state_d = READY;
`else
        state_d = READY;
`endif
      end
      default: ;
    endcase
  end

  assign a_acc_c = a_req & init_done;
  assign b_acc_c = b_req & init_done;
  assign a_rd_c  = a_acc_c & ~a_we;
  assign b_rd_c  = b_acc_c & ~b_we;

  // The clear sweep borrows port A; no request can be accepted while it runs.
  always_comb begin
    core_a_we_c    = a_acc_c & a_we;
    core_a_be_c    = a_be;
    core_a_addr_c  = a_addr;
    core_a_wdata_c = a_wdata;
`ifdef DPRAM_INIT_CLEAR_EN
    if (state_q == CLEAR) begin
      core_a_we_c    = 1'b1;
      core_a_be_c    = '1;
      core_a_addr_c  = clr_addr_q;
      core_a_wdata_c = '0;
    end
`endif
  end

  dpram_core #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_core (
    .clk       (clk),
    .a_we      (core_a_we_c),
    .a_be      (core_a_be_c),
    .a_addr    (core_a_addr_c),
    .a_wdata   (core_a_wdata_c),
    .a_rdata_c (a_mem_c),
    .b_we      (b_acc_c & b_we),
    .b_be      (b_be),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_rdata_c (b_mem_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done <= 1'b0;
      collision <= 1'b0;
    end else begin
      init_done <= (state_d == READY);
      collision <= a_acc_c & a_we & b_acc_c & b_we & (a_addr == b_addr) & (|(a_be & b_be));
    end
  end

  if (RD_LATENCY == RD_REG) begin : g_rd_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_rdata  <= '0;
        a_rvalid <= 1'b0;
        b_rdata  <= '0;
        b_rvalid <= 1'b0;
      end else begin
        a_rvalid <= a_rd_c;
        b_rvalid <= b_rd_c;
        if (a_rd_c) a_rdata <= a_mem_c;
        if (b_rd_c) b_rdata <= b_mem_c;
      end
    end
  end else if (RD_LATENCY == RD_COMB) begin : g_rd_comb
    assign a_rdata  = a_mem_c;
    assign a_rvalid = a_rd_c;
    assign b_rdata  = b_mem_c;
    assign b_rvalid = b_rd_c;
  end else begin : g_rd_bad
    $fatal(1, "dual_port_ram_be: RD_LATENCY must be 0 or 1");
  end

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Directed bench: a registered-read and a combinational-read instance share one stimulus stream.
module tb_dual_port_ram_be;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;
`ifdef DPRAM_INIT_CLEAR_EN
  localparam int INIT_CYC = 16;
`else
  localparam int INIT_CYC = 1;
`endif

  logic              clk;
  logic              rst_n;
  logic              a_req, a_we, b_req, b_we;
  logic [3:0]        a_be, b_be;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_wdata, b_wdata;

  logic [DATA_W-1:0] r_a_rdata, r_b_rdata, c_a_rdata, c_b_rdata;
  logic              r_a_rvalid, r_b_rvalid, r_init_done, r_collision;
  logic              c_a_rvalid, c_b_rvalid, c_init_done, c_collision;

  int checks;
  int errors;
  int n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dual_port_ram_be #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(1)) u_reg (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(r_a_rdata), .a_rvalid(r_a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(r_b_rdata), .b_rvalid(r_b_rvalid),
    .init_done(r_init_done), .collision(r_collision)
  );

  dual_port_ram_be #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(0)) u_comb (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(c_a_rdata), .a_rvalid(c_a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(c_b_rdata), .b_rvalid(c_b_rvalid),
    .init_done(c_init_done), .collision(c_collision)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_req = 1'b0; a_we = 1'b0; a_be = '0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_be = '0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic set_a(input logic we, input logic [3:0] be, input logic [3:0] addr,
                       input logic [31:0] data);
    a_req = 1'b1; a_we = we; a_be = be; a_addr = addr; a_wdata = data;
  endtask

  task automatic set_b(input logic we, input logic [3:0] be, input logic [3:0] addr,
                       input logic [31:0] data);
    b_req = 1'b1; b_we = we; b_be = be; b_addr = addr; b_wdata = data;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle();
    repeat (3) tick();

    // Reset state
    check("rst_a_rdata", r_a_rdata, 32'h0);
    check("rst_b_rdata", r_b_rdata, 32'h0);
    check("rst_a_rvalid", 32'(r_a_rvalid), 32'h0);
    check("rst_b_rvalid", 32'(r_b_rvalid), 32'h0);
    check("rst_init_done", 32'(r_init_done), 32'h0);
    check("rst_collision", 32'(r_collision), 32'h0);

    // Release and measure init latency; a write in cycle 5 lands inside a clear sweep
    rst_n = 1'b1;
    check("init_low_at_release", 32'(r_init_done), 32'h0);
    n = 0;
    while (r_init_done !== 1'b1 && n < 100) begin
      if (n == 4) set_a(1'b1, 4'hF, 4'd5, 32'hFFFF_FFFF);
      else        idle();
      tick();
      n++;
    end
    idle();
    check("init_latency", 32'(n), 32'(INIT_CYC));
    check("init_done_comb_inst", 32'(c_init_done), 32'h1);

`ifdef DPRAM_INIT_CLEAR_EN
    set_a(1'b0, 4'h0, 4'd5, 32'h0);
    tick();
    idle();
    check("sweep_write_ignored", r_a_rdata, 32'h0);
`endif

    // Byte-strobed partial writes and a be=0 no-op
    set_a(1'b1, 4'hF, 4'd3, 32'hDEAD_BEEF);
    tick();
    set_a(1'b1, 4'h5, 4'd3, 32'h1122_3344);
    tick();
    set_a(1'b1, 4'h0, 4'd3, 32'h0000_0000);
    tick();
    set_a(1'b0, 4'h0, 4'd3, 32'h0);
    @(negedge clk);
    check("comb_a_rdata_merge", c_a_rdata, 32'hDE22_BE44);
    check("comb_a_rvalid", 32'(c_a_rvalid), 32'h1);
    check("reg_a_rvalid_before", 32'(r_a_rvalid), 32'h0);
    tick();
    idle();
    check("reg_a_rdata_merge", r_a_rdata, 32'hDE22_BE44);
    check("reg_a_rvalid", 32'(r_a_rvalid), 32'h1);
    tick();
    check("reg_a_rvalid_drop", 32'(r_a_rvalid), 32'h0);
    check("reg_a_rdata_hold", r_a_rdata, 32'hDE22_BE44);

    // Same-address double write with overlapping strobes
    set_a(1'b1, 4'hF, 4'd7, 32'h1234_5678);
    tick();
    set_a(1'b1, 4'h3, 4'd7, 32'hAAAA_AAAA);
    set_b(1'b1, 4'h6, 4'd7, 32'hBBBB_BBBB);
    tick();
    idle();
    check("collision_reg", 32'(r_collision), 32'h1);
    check("collision_comb", 32'(c_collision), 32'h1);
    set_b(1'b0, 4'h0, 4'd7, 32'h0);
    tick();
    idle();
    check("collision_one_cycle", 32'(r_collision), 32'h0);
    check("collision_merge_data", r_b_rdata, 32'h12BB_AAAA);
    check("collision_merge_rvalid", 32'(r_b_rvalid), 32'h1);

    // Disjoint strobes on one address, then overlapping strobes on distinct addresses
    set_a(1'b1, 4'h3, 4'd8, 32'h1111_1111);
    set_b(1'b1, 4'hC, 4'd8, 32'h2222_2222);
    tick();
    idle();
    check("no_collision_disjoint_be", 32'(r_collision), 32'h0);
    set_a(1'b1, 4'hF, 4'd9, 32'h9999_9999);
    set_b(1'b1, 4'hF, 4'd10, 32'hAAAA_0000);
    tick();
    idle();
    check("no_collision_diff_addr", 32'(r_collision), 32'h0);
    set_a(1'b0, 4'h0, 4'd8, 32'h0);
    set_b(1'b0, 4'h0, 4'd8, 32'h0);
    tick();
    idle();
    check("disjoint_a_rdata", r_a_rdata, 32'h2222_1111);
    check("disjoint_b_rdata", r_b_rdata, 32'h2222_1111);
    check("no_collision_reads", 32'(r_collision), 32'h0);
    set_b(1'b0, 4'h0, 4'd10, 32'h0);
    tick();
    idle();
    check("diff_addr_b_data", r_b_rdata, 32'hAAAA_0000);

    // Cross-port read-during-write returns the old word
    set_a(1'b1, 4'hF, 4'd2, 32'hCAFE_F00D);
    tick();
    set_a(1'b1, 4'hF, 4'd2, 32'h0000_0055);
    set_b(1'b0, 4'h0, 4'd2, 32'h0);
    @(negedge clk);
    check("rdw_comb_old", c_b_rdata, 32'hCAFE_F00D);
    check("rdw_comb_rvalid", 32'(c_b_rvalid), 32'h1);
    tick();
    a_req = 1'b0;
    a_we  = 1'b0;
    check("rdw_reg_old", r_b_rdata, 32'hCAFE_F00D);
    check("rdw_reg_rvalid", 32'(r_b_rvalid), 32'h1);
    @(negedge clk);
    check("rdw_comb_new", c_b_rdata, 32'h0000_0055);
    tick();
    idle();
    check("rdw_reg_new", r_b_rdata, 32'h0000_0055);

    // Asynchronous reset while operating
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_a_rdata", r_a_rdata, 32'h0);
    check("async_rst_b_rdata", r_b_rdata, 32'h0);
    check("async_rst_init_done", 32'(r_init_done), 32'h0);
    tick();
    rst_n = 1'b1;
    repeat (9) tick();
`ifdef DPRAM_INIT_CLEAR_EN
    check("mid_sweep_init_low", 32'(r_init_done), 32'h0);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_init_done", 32'(r_init_done), 32'h0);
    check("mid_rst_comb_init", 32'(c_init_done), 32'h0);
    tick();
    rst_n = 1'b1;
    n = 0;
    while (r_init_done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("reinit_latency", 32'(n), 32'(INIT_CYC));

`ifdef DPRAM_INIT_CLEAR_EN
    for (int i = 0; i < 16; i++) begin
      set_b(1'b0, 4'h0, 4'(i), 32'h0);
      tick();
      check($sformatf("cleared_word_%0d", i), r_b_rdata, 32'h0);
    end
    idle();
`endif

    // Write then combinational read in the same cycle on the latency-0 instance
    set_a(1'b1, 4'hF, 4'd1, 32'h0BAD_CAFE);
    tick();
    set_a(1'b0, 4'h0, 4'd1, 32'h0);
    @(negedge clk);
    check("comb_read_addr1", c_a_rdata, 32'h0BAD_CAFE);
    check("comb_rvalid_addr1", 32'(c_a_rvalid), 32'h1);
    tick();
    idle();
    check("reg_read_addr1", r_a_rdata, 32'h0BAD_CAFE);
    @(negedge clk);
    check("comb_rvalid_idle", 32'(c_a_rvalid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
